// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock set-mode controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN           = 2'b00,
    SET_HOUR      = 2'b01,
    SET_MIN       = 2'b10,
    STATE_ILLEGAL = 2'b11
  } state_t;

  localparam int unsigned HOUR_HI_BIT = 3;
  localparam int unsigned HOUR_LO_BIT = 2;
  localparam int unsigned MIN_HI_BIT  = 1;
  localparam int unsigned MIN_LO_BIT  = 0;

  // Blank the digits being edited while the blink phase is high.
  function automatic logic [3:0] blink_mask(input state_t st, input logic phase);
    logic [3:0] m;
    m = '0;
    case (st)
      SET_HOUR: begin
        m[HOUR_HI_BIT] = phase;
        m[HOUR_LO_BIT] = phase;
      end
      SET_MIN: begin
        m[MIN_HI_BIT] = phase;
        m[MIN_LO_BIT] = phase;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button to debounced level plus one-cycle press pulse on the debounced rise.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // Level flips only after a full run of disagreeing samples.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven run/set sequencer for the digital clock: mode FSM, auto-repeat,
// digit blink and colon dot.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16,
  parameter int unsigned BLINK_HALF      = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       advanceBtn,
  input  logic       incrementBtn,
  input  logic       secTick,
  output logic       runEn,
  output logic       incHour,
  output logic       incMin,
  output logic       clearSec,
  output logic [3:0] blinkMask,
  output logic       dot,
  output logic [1:0] debugState
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);
  localparam int unsigned BW      = $clog2(BLINK_HALF + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);

  logic adv_press, adv_level_unused, inc_press, inc_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv (
    .clock (clock),
    .reset (reset),
    .raw   (advanceBtn),
    .level (adv_level_unused),
    .press (adv_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clock (clock),
    .reset (reset),
    .raw   (incrementBtn),
    .level (inc_level),
    .press (inc_press)
  );

  state_t        state, state_n;
  logic [RW-1:0] rpt_cnt, rpt_cnt_n;
  logic          rpt_active, rpt_active_n;
  logic          rpt_first, rpt_first_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          phase, phase_n;
  logic          press_fire, rpt_fire;
  logic          inc_hour_n, inc_min_n, clear_n, dot_n;

  assign debugState = state;

  always_comb begin
    state_n      = state;
    clear_n      = 1'b0;
    press_fire   = 1'b0;
    rpt_fire     = 1'b0;
    rpt_cnt_n    = rpt_cnt;
    rpt_active_n = rpt_active;
    rpt_first_n  = rpt_first;
    blink_cnt_n  = blink_cnt + BW'(1);
    phase_n      = phase;
    dot_n        = dot;

    if (blink_cnt == BLINK_LAST) begin
      blink_cnt_n = '0;
      phase_n     = ~phase;
    end

    // Advance takes priority over an increment press in the same cycle.
    case (state)
      RUN: begin
        if (adv_press) state_n = SET_HOUR;
      end
      SET_HOUR: begin
        if (adv_press)      state_n = SET_MIN;
        else if (inc_press) press_fire = 1'b1;
      end
      SET_MIN: begin
        if (adv_press) begin
          state_n = RUN;
          clear_n = 1'b1;
        end else if (inc_press) begin
          press_fire = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase

    // Repeat only follows a press accepted in the current state.
    if (state_n != state) begin
      rpt_active_n = 1'b0;
      rpt_cnt_n    = '0;
    end else if (press_fire) begin
      rpt_active_n = 1'b1;
      rpt_first_n  = 1'b1;
      rpt_cnt_n    = '0;
    end else if (rpt_active && inc_level) begin
      if (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_first_n = 1'b0;
        rpt_cnt_n   = '0;
      end else begin
        rpt_cnt_n = rpt_cnt + RW'(1);
      end
    end else begin
      rpt_active_n = 1'b0;
      rpt_cnt_n    = '0;
    end

    inc_hour_n = (press_fire | rpt_fire) & (state == SET_HOUR);
    inc_min_n  = (press_fire | rpt_fire) & (state == SET_MIN);

    // Restart the blink so an edited value shows immediately.
    if ((state_n != state) || press_fire || rpt_fire) begin
      blink_cnt_n = '0;
      phase_n     = 1'b0;
    end

    if (state_n != RUN)   dot_n = 1'b1;
    else if (state != RUN) dot_n = 1'b0;
    else if (secTick)     dot_n = ~dot;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= RUN;
      rpt_cnt    <= '0;
      rpt_active <= 1'b0;
      rpt_first  <= 1'b0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      runEn      <= 1'b1;
      incHour    <= 1'b0;
      incMin     <= 1'b0;
      clearSec   <= 1'b0;
      blinkMask  <= '0;
      dot        <= 1'b0;
    end else begin
      state      <= state_n;
      rpt_cnt    <= rpt_cnt_n;
      rpt_active <= rpt_active_n;
      rpt_first  <= rpt_first_n;
      blink_cnt  <= blink_cnt_n;
      phase      <= phase_n;
      runEn      <= (state_n == RUN);
      incHour    <= inc_hour_n;
      incMin     <= inc_min_n;
      clearSec   <= clear_n;
      blinkMask  <= blink_mask(state_n, phase_n);
      dot        <= dot_n;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: command pulses are matched against queued
// (kind, cycle) expectations; levels are checked at hand-computed cycles.
module tb_clock_set_ctrl;
  import clock_ctrl_pkg::*;

  localparam int DB = 16;
  localparam int RD = 64;
  localparam int RP = 16;
  localparam int BH = 32;
  localparam int LAT = DB + 4;   // raw rise to command/state update

  localparam int EV_HOUR = 1;
  localparam int EV_MIN  = 2;
  localparam int EV_CLR  = 3;

  logic       clock = 1'b0;
  logic       reset, advanceBtn, incrementBtn, secTick;
  logic       runEn, incHour, incMin, clearSec, dot;
  logic [3:0] blinkMask;
  logic [1:0] debugState;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_kind[$];
  int exp_cyc[$];

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .BLINK_HALF(BH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .advanceBtn   (advanceBtn),
    .incrementBtn (incrementBtn),
    .secTick      (secTick),
    .runEn        (runEn),
    .incHour      (incHour),
    .incMin       (incMin),
    .clearSec     (clearSec),
    .blinkMask    (blinkMask),
    .dot          (dot),
    .debugState   (debugState)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every command pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    logic [2:0] p;
    int ek, ec;
    p = {clearSec, incMin, incHour};
    for (int i = 0; i < 3; i++) begin
      if (p[i] === 1'b1) begin
        total++;
        if (exp_kind.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse kind=%0d at cyc=%0d (none expected)", i + 1, cyc);
        end else begin
          ek = exp_kind.pop_front();
          ec = exp_cyc.pop_front();
          if (ek != i + 1 || ec != cyc) begin
            bad++;
            $display("FAIL pulse got kind=%0d cyc=%0d want kind=%0d cyc=%0d", i + 1, cyc, ek, ec);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cyc=%0d", name, act, want, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int c);
    exp_kind.push_back(kind);
    exp_cyc.push_back(c);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic adv_tap();
    int t0;
    t0 = cyc;
    advanceBtn = 1'b1;
    wait_to(t0 + 25);
    advanceBtn = 1'b0;
    wait_to(t0 + 50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    reset = 1'b0; advanceBtn = 1'b0; incrementBtn = 1'b0; secTick = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst_runEn", 32'(runEn), 1);
    chk("rst_state", 32'(debugState), 0);
    chk("rst_mask", 32'(blinkMask), 0);
    chk("rst_dot", 32'(dot), 0);
    chk("rst_pulses", 32'({incHour, incMin, clearSec}), 0);
    reset = 1'b1;
    @(negedge clock);

    // Colon toggles on each second tick in RUN.
    for (int i = 0; i < 3; i++) begin
      secTick = 1'b1;
      @(negedge clock);
      secTick = 1'b0;
      chk("dot_tick", 32'(dot), (i % 2 == 0) ? 1 : 0);
      repeat (3) @(negedge clock);
    end

    // Short glitch never becomes a press.
    advanceBtn = 1'b1;
    repeat (8) @(negedge clock);
    advanceBtn = 1'b0;
    repeat (30) @(negedge clock);
    chk("glitch_state", 32'(debugState), 0);
    chk("glitch_runEn", 32'(runEn), 1);

    // Held advance: SET_HOUR at LAT, hour digits blink every BH cycles.
    t0 = cyc;
    advanceBtn = 1'b1;
    wait_to(t0 + LAT - 1);
    chk("adv_before", 32'(debugState), 0);
    wait_to(t0 + LAT);
    chk("adv_state", 32'(debugState), 1);
    chk("adv_runEn", 32'(runEn), 0);
    chk("adv_mask0", 32'(blinkMask), 0);
    chk("adv_dot", 32'(dot), 1);
    wait_to(t0 + 30);
    advanceBtn = 1'b0;
    wait_to(t0 + LAT + BH - 1);
    chk("blink_pre", 32'(blinkMask), 0);
    wait_to(t0 + LAT + BH);
    chk("blink_on", 32'(blinkMask), 32'hc);
    wait_to(t0 + LAT + 2 * BH);
    chk("blink_off", 32'(blinkMask), 0);

    // Increment held 180 cycles: press pulse, then repeats until the debounced release.
    t0 = cyc;
    expect_ev(EV_HOUR, t0 + LAT);
    for (int k = 0; k < 8; k++) expect_ev(EV_HOUR, t0 + LAT + RD + k * RP);
    incrementBtn = 1'b1;
    wait_to(t0 + 180);
    incrementBtn = 1'b0;
    wait_to(t0 + 260);
    chk("rpt_state", 32'(debugState), 1);
    chk("rpt_all_seen", 32'(exp_kind.size()), 0);

    // SET_HOUR -> SET_MIN, minute digits blink.
    t0 = cyc;
    advanceBtn = 1'b1;
    wait_to(t0 + LAT);
    chk("min_state", 32'(debugState), 2);
    chk("min_mask0", 32'(blinkMask), 0);
    wait_to(t0 + 25);
    advanceBtn = 1'b0;
    wait_to(t0 + LAT + BH);
    chk("min_blink", 32'(blinkMask), 32'h3);
    wait_to(t0 + 60);

    // SET_MIN -> RUN clears seconds once and restarts the colon.
    t0 = cyc;
    expect_ev(EV_CLR, t0 + LAT);
    advanceBtn = 1'b1;
    wait_to(t0 + LAT);
    chk("run_state", 32'(debugState), 0);
    chk("run_runEn", 32'(runEn), 1);
    chk("run_dot", 32'(dot), 0);
    chk("run_mask", 32'(blinkMask), 0);
    wait_to(t0 + 25);
    advanceBtn = 1'b0;
    wait_to(t0 + 50);

    // Increment in RUN is ignored.
    t0 = cyc;
    incrementBtn = 1'b1;
    wait_to(t0 + 25);
    incrementBtn = 1'b0;
    wait_to(t0 + 60);
    chk("runinc_state", 32'(debugState), 0);

    // Both buttons together in SET_MIN: advance wins, no incMin.
    adv_tap();
    adv_tap();
    chk("both_pre", 32'(debugState), 2);
    t0 = cyc;
    expect_ev(EV_CLR, t0 + LAT);
    advanceBtn = 1'b1;
    incrementBtn = 1'b1;
    wait_to(t0 + LAT);
    chk("both_state", 32'(debugState), 0);
    wait_to(t0 + 100);
    advanceBtn = 1'b0;
    incrementBtn = 1'b0;
    wait_to(t0 + 130);

    // Illegal encoding recovers to RUN on the next edge.
    force dut.state = STATE_ILLEGAL;
    #1;
    chk("illegal_seen", 32'(debugState), 3);
    release dut.state;
    @(negedge clock);
    chk("illegal_state", 32'(debugState), 0);
    chk("illegal_runEn", 32'(runEn), 1);
    chk("illegal_dot", 32'(dot), 0);

    // Reset in SET_MIN with increment held.
    adv_tap();
    adv_tap();
    chk("rst2_pre", 32'(debugState), 2);
    t0 = cyc;
    expect_ev(EV_MIN, t0 + LAT);
    incrementBtn = 1'b1;
    wait_to(t0 + 30);
    reset = 1'b0;
    @(negedge clock);
    chk("rst2_state", 32'(debugState), 0);
    chk("rst2_runEn", 32'(runEn), 1);
    chk("rst2_mask", 32'(blinkMask), 0);
    chk("rst2_dot", 32'(dot), 0);
    chk("rst2_pulses", 32'({incHour, incMin, clearSec}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    // Entering SET_HOUR with increment still held produces no incHour.
    adv_tap();
    chk("held_state", 32'(debugState), 1);
    repeat (120) @(negedge clock);
    incrementBtn = 1'b0;
    repeat (40) @(negedge clock);

    chk("queue_empty", 32'(exp_kind.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
